// File: rtl/mccpu_ctrl_if.sv
// rtl/mccpu_ctrl_if.sv - multi-cycle CPU controller bundle: decode inputs, control strobes, status
interface mccpu_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       Op;
   logic [5:0]       Funct;
   logic             Zero;
   logic             mem_ready;
   logic             PCWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             IorD;
   logic             EXTOp;
   logic [3:0]       ALUOp;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       PCSource;
   logic [1:0]       GPRSel;
   logic [1:0]       WDSel;
   logic [2:0]       state;
   logic             err;
   logic [CNT_W-1:0] retired;

   modport master (
      input  Op, Funct, Zero, mem_ready,
      output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
      output ALUOp, ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel, state, err, retired
   );

   modport slave (
      output Op, Funct, Zero, mem_ready,
      input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
      input  ALUOp, ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel, state, err, retired
   );
endinterface

// File: rtl/mccpu_ctrl.sv
// rtl/mccpu_ctrl.sv - multi-cycle MIPS-subset controller FSM with memory timeout and retire counter
// Optional jal/jr support is enabled by defining MCCTRL_JAL_EN.
module mccpu_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic           clk,
   input  logic           rstn,
   mccpu_ctrl_if.master   bus
);
   typedef enum logic [2:0] {
      S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_ILL, C_R, C_IALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
   } cls_t;

   localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                          ALU_OR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                          ALU_NOR = 4'd8;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t           state;
   cls_t             cls;
   logic [7:0]       wait_cnt;
   logic [CNT_W-1:0] retired;
   logic [3:0]       dec_alu;
   logic [1:0]       dec_srca;
   logic             dec_ext;

   always_comb begin
      cls      = C_ILL;
      dec_alu  = ALU_NOP;
      dec_srca = 2'b00;
      dec_ext  = 1'b0;
      case (bus.Op)
         6'b000000: begin
            cls = C_R;
            case (bus.Funct)
               6'b100000, 6'b100001: dec_alu = ALU_ADD;
               6'b100010, 6'b100011: dec_alu = ALU_SUB;
               6'b100100: dec_alu = ALU_AND;
               6'b100101: dec_alu = ALU_OR;
               6'b100111: dec_alu = ALU_NOR;
               6'b101010: dec_alu = ALU_SLT;
               6'b101011: dec_alu = ALU_SLTU;
               6'b000000: begin dec_alu = ALU_SLL; dec_srca = 2'b01; end
`ifdef MCCTRL_JAL_EN
               6'b001000: cls = C_JR;
`endif
               default:   cls = C_ILL;
            endcase
         end
         6'b001000: begin cls = C_IALU; dec_alu = ALU_ADD; dec_ext = 1'b1; end
         6'b001101: begin cls = C_IALU; dec_alu = ALU_OR; end
         6'b001111: begin cls = C_IALU; dec_alu = ALU_ADD; dec_srca = 2'b10; end
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b000010: cls = C_J;
`ifdef MCCTRL_JAL_EN
         6'b000011: cls = C_JAL;
`endif
         default:   cls = C_ILL;
      endcase
   end

   // Every return to IF from a working state counts one retired instruction.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IF;
         wait_cnt <= 8'd0;
         retired  <= '0;
      end else begin
         case (state)
            S_IF: begin
               if (bus.mem_ready) begin
                  state <= S_ID;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= S_ERR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_ID: begin
               case (cls)
                  C_J, C_JAL, C_JR: begin
                     state    <= S_IF;
                     wait_cnt <= 8'd0;
                     retired  <= retired + 1'b1;
                  end
                  C_ILL:   state <= S_ERR;
                  default: state <= S_EX;
               endcase
            end
            S_EX: begin
               case (cls)
                  C_LW, C_SW: begin
                     state    <= S_MEM;
                     wait_cnt <= 8'd0;
                  end
                  C_BEQ: begin
                     state    <= S_IF;
                     wait_cnt <= 8'd0;
                     retired  <= retired + 1'b1;
                  end
                  default: state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  if (cls == C_LW) begin
                     state <= S_WB;
                  end else begin
                     state    <= S_IF;
                     wait_cnt <= 8'd0;
                     retired  <= retired + 1'b1;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= S_ERR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WB: begin
               state    <= S_IF;
               wait_cnt <= 8'd0;
               retired  <= retired + 1'b1;
            end
            default: state <= S_ERR;
         endcase
      end
   end

   logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord, ext_op;
   logic [3:0] alu_op;
   logic [1:0] src_a, src_b, pc_src, gpr_sel, wd_sel;

   always_comb begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      ext_op    = 1'b0;
      alu_op    = ALU_NOP;
      src_a     = 2'b00;
      src_b     = 2'b00;
      pc_src    = 2'b00;
      gpr_sel   = 2'b00;
      wd_sel    = 2'b00;
      case (state)
         S_IF: begin
            mem_read = 1'b1;
            src_b    = 2'b01;
            alu_op   = ALU_ADD;
            pc_write = bus.mem_ready;
            ir_write = bus.mem_ready;
         end
         S_ID: begin
            src_b  = 2'b11;
            alu_op = ALU_ADD;
            ext_op = 1'b1;
            case (cls)
               C_J:   begin pc_write = 1'b1; pc_src = 2'b10; end
               C_JAL: begin
                  pc_write  = 1'b1;
                  pc_src    = 2'b10;
                  reg_write = 1'b1;
                  gpr_sel   = 2'b10;
                  wd_sel    = 2'b10;
               end
               C_JR:  begin pc_write = 1'b1; pc_src = 2'b11; end
               default: ;
            endcase
         end
         S_EX: begin
            case (cls)
               C_R:    begin alu_op = dec_alu; src_a = dec_srca; end
               C_IALU: begin alu_op = dec_alu; src_a = dec_srca; src_b = 2'b10; ext_op = dec_ext; end
               C_LW, C_SW: begin alu_op = ALU_ADD; src_b = 2'b10; ext_op = 1'b1; end
               C_BEQ:  begin alu_op = ALU_SUB; pc_src = 2'b01; pc_write = bus.Zero; end
               default: ;
            endcase
         end
         S_MEM: begin
            iord      = 1'b1;
            mem_read  = (cls == C_LW);
            mem_write = (cls == C_SW);
         end
         S_WB: begin
            reg_write = 1'b1;
            if (cls == C_IALU) begin
               gpr_sel = 2'b01;
            end else if (cls == C_LW) begin
               gpr_sel = 2'b01;
               wd_sel  = 2'b01;
            end
         end
         default: ;
      endcase
      // The reset state is IF, so the strobes are masked to keep a held mem_ready from leaking through.
      if (!rstn) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

   assign bus.PCWrite  = pc_write;
   assign bus.IRWrite  = ir_write;
   assign bus.RegWrite = reg_write;
   assign bus.MemRead  = mem_read;
   assign bus.MemWrite = mem_write;
   assign bus.IorD     = iord;
   assign bus.EXTOp    = ext_op;
   assign bus.ALUOp    = alu_op;
   assign bus.ALUSrcA  = src_a;
   assign bus.ALUSrcB  = src_b;
   assign bus.PCSource = pc_src;
   assign bus.GPRSel   = gpr_sel;
   assign bus.WDSel    = wd_sel;
   assign bus.state    = state;
   assign bus.err      = (state == S_ERR);
   assign bus.retired  = retired;
endmodule
